// File: rtl/spi_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_master                                                   |
// | Description : SPI mode-0 initiator, MSB first. It shifts one WIDTH-bit     |
// |               word out on mosi and captures the reply from miso.           |
// |               Optional macro SPI_LOOPBACK_EN adds a loopback input port.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_master #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] txData,
    output logic [WIDTH-1:0] rxData,
    output logic             busy,
    output logic             done,
    output logic             cs,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso
`ifdef SPI_LOOPBACK_EN
    ,
    input  logic             loopback
`endif
);

    localparam int c_divWidth = $clog2(CLK_DIV + 1);
    localparam int c_bitWidth = $clog2(WIDTH);
    localparam logic [c_divWidth-1:0] c_divLast = c_divWidth'(CLK_DIV - 1);
    localparam logic [c_bitWidth-1:0] c_bitLast = c_bitWidth'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIGH = 3'd2,
        S_SLOW  = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                r_state;
    logic [c_divWidth-1:0] r_div;
    logic [c_bitWidth-1:0] r_bitCount;
    logic [WIDTH-1:0]      r_txShift;
    logic [WIDTH-1:0]      r_rxShift;
    logic [WIDTH-1:0]      r_rxData;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_cs;
    logic                  r_sclk;
    logic                  w_phaseEnd;
    logic                  w_sampleBit;
    logic                  w_timedPhase;

    assign w_phaseEnd   = (r_div == c_divLast);
    assign w_timedPhase = (r_state == S_SETUP) || (r_state == S_SHIGH) ||
                          (r_state == S_SLOW)  || (r_state == S_HOLD);

`ifdef SPI_LOOPBACK_EN
    logic r_loopSel;
    // The MSB of the tx shifter is the bit currently on mosi.
    assign w_sampleBit = r_loopSel ? r_txShift[WIDTH-1] : miso;
`else
    assign w_sampleBit = miso;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bitCount <= '0;
            r_txShift  <= '0;
            r_rxShift  <= '0;
            r_rxData   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cs       <= 1'b1;
            r_sclk     <= 1'b0;
`ifdef SPI_LOOPBACK_EN
            r_loopSel  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_timedPhase) begin
                r_div <= w_phaseEnd ? '0 : r_div + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_txShift  <= txData;
                        r_div      <= '0;
                        r_bitCount <= '0;
                        r_cs       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_sclk     <= 1'b0;
`ifdef SPI_LOOPBACK_EN
                        r_loopSel  <= loopback;
`endif
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP, S_SLOW: begin
                    // miso is captured on the same edge that raises sclk, i.e.
                    // before the peripheral shifts out its next bit.
                    if (w_phaseEnd) begin
                        r_sclk    <= 1'b1;
                        r_rxShift <= {r_rxShift[WIDTH-2:0], w_sampleBit};
                        r_state   <= S_SHIGH;
                    end
                end
                S_SHIGH: begin
                    if (w_phaseEnd) begin
                        r_sclk <= 1'b0;
                        if (r_bitCount == c_bitLast) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_txShift  <= r_txShift << 1;
                            r_bitCount <= r_bitCount + 1'b1;
                            r_state    <= S_SLOW;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_phaseEnd) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_cs       <= 1'b1;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_rxData   <= r_rxShift;
                    r_bitCount <= '0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rxData = r_rxData;
    assign busy   = r_busy;
    assign done   = r_done;
    assign cs     = r_cs;
    assign sclk   = r_sclk;
    assign mosi   = r_txShift[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_master                                                |
// | Description : Scoreboard bench for spi_master with a shift-register        |
// |               peripheral model. Loopback case under SPI_LOOPBACK_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_master;

    localparam int c_width   = 8;
    localparam int c_clkDiv  = 4;
    localparam int c_latency = (2 * c_width + 1) * c_clkDiv + 1;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] periph;
        int         acc;
        int         riseMark;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] txData = 8'h00;
    logic [7:0] rxData;
    logic       busy, done, cs, sclk, mosi, miso;
    logic       loopbackIn = 1'b0;

    logic [7:0] pReg = 8'h00;
    logic [7:0] pPre = 8'h00;
    logic       pLoad = 1'b0;
    int         misoMode = 0;
    int         riseTotal = 0;
    int         cyc = 0;
    int         doneCount = 0;
    int         nIssued = 0;
    int         nCmp = 0;
    int         nBad = 0;
    exp_t       sbq[$];

    spi_master #(.WIDTH(c_width), .CLK_DIV(c_clkDiv)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .txData  (txData),
        .rxData  (rxData),
        .busy    (busy),
        .done    (done),
        .cs      (cs),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso)
`ifdef SPI_LOOPBACK_EN
        ,
        .loopback(loopbackIn)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral: shifts mosi in on every sclk rise, presents its MSB on miso.
    always @(posedge sclk or posedge pLoad) begin
        if (pLoad) pReg <= pPre;
        else       pReg <= {pReg[6:0], mosi};
    end
    always @(posedge sclk) riseTotal <= riseTotal + 1;
    assign miso = (misoMode == 1) ? 1'b1 : (misoMode == 2) ? 1'b0 : pReg[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: what the master must return for each miso source.
    function automatic logic [7:0] refRx(input int mode, input logic [7:0] tx, input logic [7:0] pre);
        case (mode)
            1:       return 8'hFF;
            2:       return tx;
            3:       return 8'h00;
            default: return pre;
        endcase
    endfunction

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (done) begin
            doneCount++;
            if (sbq.size() == 0) begin
                check("unexpected done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("rxData", 32'(rxData), 32'(e.rx));
                check("peripheral word", 32'(pReg), 32'(e.periph));
                check("latency", 32'(cyc - e.acc), 32'(c_latency));
                check("sclk rises", 32'(riseTotal - e.riseMark), 32'(c_width));
                check("cs at done", 32'(cs), 32'd1);
                check("busy at done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic doXfer(input logic [7:0] tx, input logic [7:0] pre, input int mode,
                          output int acc, output int mark);
        exp_t e;
        @(negedge clk);
        pPre = pre;
        pLoad = 1'b1;
        #1 pLoad = 1'b0;
        misoMode = (mode == 2) ? 2 : mode;
        loopbackIn = (mode == 2);
        txData = tx;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc = cyc;
        mark = riseTotal;
        e.rx = refRx(mode, tx, pre);
        e.periph = tx;
        e.acc = acc;
        e.riseMark = mark;
        sbq.push_back(e);
        nIssued++;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        if (sbq.size() != 0) begin
            check("transfer timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    initial begin
        int acc, mark, n;
        logic [7:0] tx1, tx2, pre;

        repeat (2) @(posedge clk);
        #1;
        check("reset cs", 32'(cs), 32'd1);
        check("reset sclk", 32'(sclk), 32'd0);
        check("reset mosi", 32'(mosi), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset rxData", 32'(rxData), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        doXfer(8'h94, 8'h3C, 0, acc, mark);
        waitIdle(200);

        doXfer(8'h00, 8'h00, 1, acc, mark);
        waitIdle(200);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            doXfer(8'($urandom), 8'($urandom), 0, acc, mark);
            waitIdle(200);
        end

        // Busy-ignore: a second start mid-transfer must not be taken.
        pre = 8'($urandom);
        doXfer(8'hA5, pre, 0, acc, mark);
        while (cyc < acc + 20) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        txData = 8'h5A;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle(200);
        repeat (100) @(posedge clk);
        check("done pulses after busy-ignore", 32'(doneCount), 32'(nIssued));

        // start held through DONE: next accept lands on the first IDLE edge.
        tx1 = 8'($urandom);
        tx2 = 8'($urandom);
        @(negedge clk);
        pPre = 8'($urandom);
        pLoad = 1'b1;
        #1 pLoad = 1'b0;
        misoMode = 0;
        loopbackIn = 1'b0;
        txData = tx1;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        mark = riseTotal;
        txData = tx2;
        sbq.push_back('{rx: pPre, periph: tx1, acc: acc, riseMark: mark});
        sbq.push_back('{rx: tx1, periph: tx2, acc: acc + c_latency + 1, riseMark: mark + c_width});
        nIssued += 2;
        do begin
            @(posedge clk);
            #1;
        end while (cyc < acc + c_latency + 1);
        start = 1'b0;
        waitIdle(300);

        // Reset after the third sclk rise aborts the transfer silently.
        doXfer(8'($urandom), 8'($urandom), 0, acc, mark);
        n = 0;
        while (riseTotal < mark + 3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("third rise reached", 32'(riseTotal - mark >= 3), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort cs", 32'(cs), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort sclk", 32'(sclk), 32'd0);
        check("abort rxData", 32'(rxData), 32'd0);
        if (sbq.size() != 0) void'(sbq.pop_back());
        nIssued--;
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(posedge clk);
        check("done pulses after abort", 32'(doneCount), 32'(nIssued));

        doXfer(8'hC3, 8'($urandom), 0, acc, mark);
        waitIdle(200);

`ifdef SPI_LOOPBACK_EN
        doXfer(8'h96, 8'h00, 2, acc, mark);
        waitIdle(200);
        loopbackIn = 1'b0;
        misoMode = 0;
`endif

        repeat (20) @(posedge clk);
        check("total done pulses", 32'(doneCount), 32'(nIssued));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
